// File: rtl/apb_protocol_checker.sv
// APB bus monitor: tracks the IDLE/SETUP/ACCESS phase sequence and records protocol
// violations as sticky flags, a one-cycle pulse and a saturating violation counter.
module apb_protocol_checker #(
  parameter int NSEL           = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [NSEL-1:0]       psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic                  clr_err,
  output logic [5:0]            err_sticky,
  output logic                  err_pulse,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  xfer_done,
  output logic [1:0]            phase
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;

  localparam int WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

  logic [1:0]            state, state_next;
  logic [NSEL-1:0]       lat_sel;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_write;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [WAIT_W-1:0]     wait_cnt, wait_next, wait_inc;
  logic [5:0]            flags;
  logic                  latch_en, done, timeout_hit;

  // Read data is observed on the bus but carries no protocol rule.
  logic unused_prdata;
  assign unused_prdata = ^prdata;

  assign phase = state;
  assign wait_inc = wait_cnt + WAIT_W'(1);
  // The counter parks at the limit, so the crossing is seen once per transfer.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt != WAIT_LIMIT) &&
                       (wait_inc == WAIT_LIMIT);

  always_comb begin
    flags      = '0;
    state_next = state;
    latch_en   = 1'b0;
    wait_next  = wait_cnt;
    done       = 1'b0;

    flags[0] = (psel & (psel - NSEL'(1))) != '0;

    case (state)
      ST_ACCESS: begin
        if (!penable || (psel != lat_sel)) begin
          flags[2]   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          flags[3] = (paddr != lat_addr) || (pwrite != lat_write) ||
                     (lat_write && (pwdata != lat_wdata));
          if (pready) begin
            done       = 1'b1;
            state_next = ST_IDLE;
          end else begin
            if (wait_cnt != WAIT_LIMIT) wait_next = wait_inc;
            flags[4] = timeout_hit;
          end
        end
      end
      default: begin
        if (penable) begin
          flags[1] = 1'b1;
        end else if (psel != '0) begin
          latch_en   = 1'b1;
          wait_next  = '0;
          state_next = ST_ACCESS;
        end
      end
    endcase

    flags[5] = pslverr && !((state == ST_ACCESS) && penable && pready);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state      <= ST_IDLE;
      lat_sel    <= '0;
      lat_addr   <= '0;
      lat_write  <= 1'b0;
      lat_wdata  <= '0;
      wait_cnt   <= '0;
      err_sticky <= '0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      xfer_done  <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_next;
      err_pulse <= |flags;
      xfer_done <= done;
      if (latch_en) begin
        lat_sel   <= psel;
        lat_addr  <= paddr;
        lat_write <= pwrite;
        lat_wdata <= pwdata;
      end
      // A clear keeps whatever this same cycle flagged.
      if (clr_err) begin
        err_sticky <= flags;
        err_count  <= (|flags) ? CNT_WIDTH'(1) : '0;
      end else begin
        err_sticky <= err_sticky | flags;
        if ((|flags) && (err_count != '1)) err_count <= err_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
